serial_bus_bridge: RTL and testbench

Slave-side endpoint of the serial bus: receives 28-bit serial request frames and presents them as a one-cycle parallel request to a local slave. For reads, it serializes a response frame back to the master. The block contains a synchronizing deserializer, a frame decoder/checker, a response serializer and a response-control FSM. It sits between the serial link pins and the parallel slave interface.

---
 rtl/serial_bus_bridge.sv | 183 ++++++++++++++++++
 tb/tb_serial_bus_bridge.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_bus_bridge.sv
// serial_bus_bridge: serial-link slave endpoint; decodes request frames to a parallel strobe and serializes read responses.
// Optional feature: define PARITY_CHECK_EN to drop request frames whose parity bit mismatches.
module serial_bus_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sdata_i,
    input  logic                  sclk_i,
    input  logic                  svalid_i,
    output logic                  sready_o,
    output logic                  sdata_o,
    output logic                  sclk_resp_o,
    output logic                  svalid_resp_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  we_o,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  err_i
);
    localparam int FW = ADDR_WIDTH + DATA_WIDTH + 4;
    localparam int CW = $clog2(FW + 1);
    localparam int BW = $clog2(FW);
`ifdef PARITY_CHECK_EN
    localparam bit CHK_PAR = 1'b1;
`else
    localparam bit CHK_PAR = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT_SLAVE, SENDING} state_t;

    logic [1:0]            sdata_s, sclk_s, svalid_s;
    logic                  sclk_q, sclk_rise;
    logic [FW-1:0]         rx_sr;
    logic [CW-1:0]         rx_cnt;
    logic                  frame_valid, frame_err;
    state_t                state, state_n;
    logic                  capture, latch_addr, ser_start;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;
    logic [FW-1:0]         resp_frame, tx_sr;
    logic [BW-1:0]         tx_cnt;
    logic                  ser_busy, ser_done, tx_phase;

    assign sclk_rise = sclk_s[1] && !sclk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sdata_s     <= '0;
            sclk_s      <= '0;
            svalid_s    <= '0;
            sclk_q      <= 1'b0;
            rx_sr       <= '0;
            rx_cnt      <= '0;
            frame_valid <= 1'b0;
        end else begin
            sdata_s     <= {sdata_s[0], sdata_i};
            sclk_s      <= {sclk_s[0], sclk_i};
            svalid_s    <= {svalid_s[0], svalid_i};
            sclk_q      <= sclk_s[1];
            frame_valid <= 1'b0;
            if (!svalid_s[1]) begin
                rx_cnt <= '0;
            end else if (sclk_rise) begin
                rx_sr <= {rx_sr[FW-2:0], sdata_s[1]};
                if (rx_cnt == CW'(FW - 1)) begin
                    rx_cnt      <= '0;
                    frame_valid <= 1'b1;
                end else begin
                    rx_cnt <= rx_cnt + CW'(1);
                end
            end
        end
    end

    // Even parity over cmd..parity folds to zero for a good frame.
    assign frame_err = !rx_sr[FW-1] || !rx_sr[0] || (CHK_PAR && (^rx_sr[FW-2:1]));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            we_o    <= 1'b0;
            addr_o  <= '0;
            wdata_o <= '0;
        end else begin
            valid_o <= frame_valid && !frame_err;
            if (frame_valid && !frame_err) begin
                we_o    <= rx_sr[FW-2];
                addr_o  <= rx_sr[FW-3 -: ADDR_WIDTH];
                wdata_o <= rx_sr[DATA_WIDTH+1:2];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n    = state;
        capture    = 1'b0;
        latch_addr = 1'b0;
        case (state)
            IDLE: if (valid_o && !we_o) begin
                latch_addr = 1'b1;
                capture    = ready_i && !ser_busy;
                state_n    = capture ? SENDING : WAIT_SLAVE;
            end
            WAIT_SLAVE: begin
                capture = ready_i && !ser_busy;
                state_n = capture ? SENDING : WAIT_SLAVE;
            end
            SENDING: state_n = ser_done ? IDLE : SENDING;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_addr <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            ser_start <= 1'b0;
        end else begin
            ser_start <= capture;
            if (latch_addr) resp_addr <= addr_o;
            if (capture) begin
                resp_data <= rdata_i;
                resp_err  <= err_i;
            end
        end
    end

    assign resp_frame = {1'b1, resp_err, resp_addr, resp_data, ^{resp_err, resp_addr, resp_data}, 1'b1};

    // Each bit: phase 0 presents data with clock low, phase 1 raises the clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ser_busy    <= 1'b0;
            ser_done    <= 1'b0;
            tx_phase    <= 1'b0;
            tx_sr       <= '0;
            tx_cnt      <= '0;
            sdata_o     <= 1'b0;
            sclk_resp_o <= 1'b0;
        end else begin
            ser_done <= 1'b0;
            if (!ser_busy) begin
                if (ser_start) begin
                    ser_busy    <= 1'b1;
                    tx_sr       <= resp_frame;
                    tx_cnt      <= '0;
                    tx_phase    <= 1'b0;
                    sdata_o     <= resp_frame[FW-1];
                    sclk_resp_o <= 1'b0;
                end
            end else if (!tx_phase) begin
                tx_phase    <= 1'b1;
                sclk_resp_o <= 1'b1;
            end else if (tx_cnt == BW'(FW - 1)) begin
                ser_busy    <= 1'b0;
                ser_done    <= 1'b1;
                tx_phase    <= 1'b0;
                sdata_o     <= 1'b0;
                sclk_resp_o <= 1'b0;
            end else begin
                tx_phase    <= 1'b0;
                tx_cnt      <= tx_cnt + BW'(1);
                tx_sr       <= {tx_sr[FW-2:0], 1'b0};
                sdata_o     <= tx_sr[FW-2];
                sclk_resp_o <= 1'b0;
            end
        end
    end

    assign svalid_resp_o = ser_busy;
    assign sready_o      = !svalid_i && !ser_busy;
endmodule

// File: tb/tb_serial_bus_bridge.sv
// tb_serial_bus_bridge: directed bench for serial_bus_bridge request decode and read response framing.
module tb_serial_bus_bridge;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sdata_i = 1'b0, sclk_i = 1'b0, svalid_i = 1'b0;
    logic        ready_i = 1'b0, err_i = 1'b0;
    logic [7:0]  rdata_i = 8'h00;
    logic        sready_o, sdata_o, sclk_resp_o, svalid_resp_o, valid_o, we_o;
    logic [15:0] addr_o;
    logic [7:0]  wdata_o;

    int vectors = 0, miscompares = 0;
    int cyc = 0, vcnt = 0, busy_cyc = 0, rx_n = 0, valid_cyc = 0, rise_cyc = 0;
    int v0, b0, r0, exp_v;
    logic [27:0] rx = '0;
    logic        prev_sclk = 1'b0, prev_busy = 1'b0, prev_valid = 1'b0;
    logic [15:0] last_addr = '0;
    logic [7:0]  last_wdata = '0;
    logic        last_we = 1'b0;

    serial_bus_bridge dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sdata_i(sdata_i), .sclk_i(sclk_i), .svalid_i(svalid_i),
        .sready_o(sready_o), .sdata_o(sdata_o), .sclk_resp_o(sclk_resp_o), .svalid_resp_o(svalid_resp_o),
        .valid_o(valid_o), .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o),
        .ready_i(ready_i), .rdata_i(rdata_i), .err_i(err_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        cyc++;
        if (valid_o) begin
            vcnt++;
            last_addr  = addr_o;
            last_wdata = wdata_o;
            last_we    = we_o;
            if (!prev_valid) valid_cyc = cyc;
        end
        if (svalid_resp_o) busy_cyc++;
        if (svalid_resp_o && !prev_busy) rise_cyc = cyc;
        if (sclk_resp_o && !prev_sclk) begin
            rx = {rx[26:0], sdata_o};
            rx_n++;
        end
        prev_valid = valid_o;
        prev_busy  = svalid_resp_o;
        prev_sclk  = sclk_resp_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [27:0] f, input int n);
        @(negedge clk_i);
        svalid_i = 1'b1;
        sclk_i   = 1'b0;
        repeat (4) @(negedge clk_i);
        for (int i = 0; i < n; i++) begin
            sdata_i = f[27-i];
            repeat (4) @(negedge clk_i);
            sclk_i = 1'b1;
            repeat (4) @(negedge clk_i);
            sclk_i = 1'b0;
        end
        repeat (4) @(negedge clk_i);
        svalid_i = 1'b0;
        sdata_i  = 1'b0;
        repeat (8) @(negedge clk_i);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_we", 32'(we_o), 0);
        check("rst_addr", 32'(addr_o), 0);
        check("rst_wdata", 32'(wdata_o), 0);
        check("rst_sdata", 32'(sdata_o), 0);
        check("rst_sclk", 32'(sclk_resp_o), 0);
        check("rst_svalid_resp", 32'(svalid_resp_o), 0);
        check("rst_sready_idle", 32'(sready_o), 1);
        svalid_i = 1'b1;
        #1 check("rst_sready_svalid", 32'(sready_o), 0);
        svalid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // write 0x1234 <= 0xA5
        v0 = vcnt; b0 = busy_cyc;
        svalid_i = 1'b1;
        #1 check("sready_during_frame", 32'(sready_o), 0);
        send({1'b1, 1'b1, 16'h1234, 8'hA5, 1'b0, 1'b1}, 28);
        check("wr_pulses", 32'(vcnt - v0), 1);
        check("wr_addr", 32'(last_addr), 32'h1234);
        check("wr_wdata", 32'(last_wdata), 32'hA5);
        check("wr_we", 32'(last_we), 1);
        check("wr_no_resp", 32'(busy_cyc - b0), 0);

        // read 0x00F0, slave ready later
        v0 = vcnt; b0 = busy_cyc; r0 = rx_n;
        send({1'b1, 1'b0, 16'h00F0, 8'h00, 1'b0, 1'b1}, 28);
        check("rd_pulses", 32'(vcnt - v0), 1);
        check("rd_we", 32'(last_we), 0);
        check("rd_addr", 32'(last_addr), 32'h00F0);
        repeat (3) @(negedge clk_i);
        check("rd_wait_no_resp", 32'(busy_cyc - b0), 0);
        rdata_i = 8'h5A;
        ready_i = 1'b1;
        repeat (10) @(negedge clk_i);
        ready_i = 1'b0;
        rdata_i = 8'h00;
        check("rd_resp_busy", 32'(svalid_resp_o), 1);
        check("rd_sready_resp", 32'(sready_o), 0);
        repeat (60) @(negedge clk_i);
        check("rd_frame", 32'(rx), 32'({1'b1, 1'b0, 16'h00F0, 8'h5A, 1'b0, 1'b1}));
        check("rd_bits", 32'(rx_n - r0), 28);
        check("rd_len", 32'(busy_cyc - b0), 56);
        check("rd_end_sclk", 32'(sclk_resp_o), 0);
        check("rd_end_sdata", 32'(sdata_o), 0);
        check("rd_end_sready", 32'(sready_o), 1);

        // immediate read with slave error
        ready_i = 1'b1; err_i = 1'b1; rdata_i = 8'h3C;
        b0 = busy_cyc;
        send({1'b1, 1'b0, 16'hABCD, 8'h00, 1'b0, 1'b1}, 28);
        repeat (60) @(negedge clk_i);
        ready_i = 1'b0; err_i = 1'b0; rdata_i = 8'h00;
        check("imm_latency", 32'(rise_cyc - valid_cyc), 2);
        check("imm_frame", 32'(rx), 32'({1'b1, 1'b1, 16'hABCD, 8'h3C, 1'b1, 1'b1}));
        check("imm_len", 32'(busy_cyc - b0), 56);

        // flipped parity
        v0 = vcnt;
        send({1'b1, 1'b1, 16'h0055, 8'h11, 1'b0, 1'b1}, 28);
`ifdef PARITY_CHECK_EN
        exp_v = 0;
`else
        exp_v = 1;
`endif
        check("bad_parity_pulses", 32'(vcnt - v0), 32'(exp_v));

        // bad stop bit
        v0 = vcnt;
        send({1'b1, 1'b1, 16'h0077, 8'h00, 1'b0, 1'b0}, 28);
        check("bad_stop_pulses", 32'(vcnt - v0), 0);

        // partial frame then full write
        v0 = vcnt;
        send({1'b1, 1'b1, 16'h1234, 8'hA5, 1'b0, 1'b1}, 10);
        send({1'b1, 1'b1, 16'h0001, 8'h00, 1'b0, 1'b1}, 28);
        check("partial_pulses", 32'(vcnt - v0), 1);
        check("partial_addr", 32'(last_addr), 32'h0001);
        check("partial_wdata", 32'(last_wdata), 0);

        // reset mid-response
        ready_i = 1'b1;
        send({1'b1, 1'b0, 16'h0002, 8'h00, 1'b1, 1'b1}, 28);
        repeat (5) @(negedge clk_i);
        check("mid_resp_busy", 32'(svalid_resp_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_svalid_resp", 32'(svalid_resp_o), 0);
        check("rst_mid_sclk", 32'(sclk_resp_o), 0);
        check("rst_mid_sdata", 32'(sdata_o), 0);
        check("rst_mid_addr", 32'(addr_o), 0);
        ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
